// File: rtl/fma_operand_mac.sv
// Multiply-accumulate engine: result = A*B + (acc_en ? result : C).
// The multiply is iterative shift-add, one multiplier bit per clock, LSB first.
// The addend is zero-extended to 25 bits so the carry out of bit 23 lands in a
// sticky overflow flag instead of being lost.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on the accepting edge
// MUL    | 8 shift-add steps, one multiplier bit per cycle
// ADD    | single cycle: product + addend, result/ovf updated on exit
// DONE   | one-cycle done pulse, then back to IDLE
module fma_operand_mac (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  input  logic [7:0]  c_in,
  input  logic        start,
  input  logic        acc_en,
  input  logic        clear,
  output logic [23:0] result,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] a_sh;
  logic [7:0]  b_sh;
  logic [7:0]  c_q;
  logic        acc_q;
  logic [15:0] prod;
  logic [2:0]  bit_cnt;
  logic [24:0] addend;
  logic [24:0] sum;

  // State register; reset outranks clear, clear outranks everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_MUL;
      ST_MUL:  if (bit_cnt == 3'd0) state_nxt = ST_ADD;
      ST_ADD:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Final add, widened by one bit to expose the accumulate carry.
  always_comb begin
    addend = acc_q ? {1'b0, result} : {17'd0, c_q};
    sum    = {9'd0, prod} + addend;
  end

  // Operand latch, shift-add multiplier and result/overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      c_q     <= '0;
      acc_q   <= 1'b0;
      prod    <= '0;
      bit_cnt <= '0;
      result  <= '0;
      ovf     <= 1'b0;
    end else if (clear) begin
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= {8'd0, a_in};
            b_sh    <= b_in;
            c_q     <= c_in;
            acc_q   <= acc_en;
            prod    <= '0;
            bit_cnt <= 3'd7;
          end
        end
        ST_MUL: begin
          if (b_sh[0]) prod <= prod + a_sh;
          a_sh    <= a_sh << 1;
          b_sh    <= b_sh >> 1;
          bit_cnt <= bit_cnt - 3'd1;
        end
        ST_ADD: begin
          result <= sum[23:0];
          if (sum[24]) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fma_operand_mac.sv
// Directed bench for fma_operand_mac with hand-computed expected values.
module tb_fma_operand_mac;

  logic        clk;
  logic        reset;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [7:0]  c_in;
  logic        start;
  logic        acc_en;
  logic        clear;
  logic [23:0] result;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_checks;
  int n_fail;

  fma_operand_mac dut (
    .clk    (clk),
    .reset  (reset),
    .a_in   (a_in),
    .b_in   (b_in),
    .c_in   (c_in),
    .start  (start),
    .acc_en (acc_en),
    .clear  (clear),
    .result (result),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and wait for done; reports latency and busy length.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic acc, input string tag);
    int lat;
    int nbusy;
    a_in = a; b_in = b; c_in = c; acc_en = acc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (done) check({tag, "_early_done"}, done, 1'b0);
      tick();
      lat++;
    end
    if (busy) nbusy++;
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, nbusy, 10);
    tick();
    check({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int ndone;
    int lat;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; clear = 1'b0; start = 1'b0; acc_en = 1'b0;
    a_in = 8'hFF; b_in = 8'hFF; c_in = 8'hFF;
    tick();
    tick();
    reset = 1'b0;
    check("rst_result", result, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // PIO reset values, plain multiply-add.
    run_op(8'hFF, 8'hFF, 8'hFF, 1'b0, "op_ffff");
    check("op_ffff_result", result, 24'h00FF00);
    check("op_ffff_ovf", ovf, 1'b0);

    // Accumulate onto previous result.
    run_op(8'hFF, 8'hFF, 8'h00, 1'b1, "acc1");
    check("acc1_result", result, 24'h01FD01);
    check("acc1_ovf", ovf, 1'b0);

    // Clear, then 259 accumulating ops back to back.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_result", result, 24'h0);
    for (int i = 1; i <= 259; i++) begin
      run_op(8'hFF, 8'hFF, 8'h00, 1'b1, "acc_chain");
      if (i == 258) begin
        check("op258_result", result, 24'hFFFD02);
        check("op258_ovf", ovf, 1'b0);
      end
    end
    check("op259_result", result, 24'h00FB03);
    check("op259_ovf", ovf, 1'b1);

    // Start re-pulsed and a_in changed while in MUL; ovf must stay sticky.
    a_in = 8'd3; b_in = 8'd5; c_in = 8'd7; acc_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a_in = 8'd0; acc_en = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      tick();
    end
    check("repulse_done_count", ndone, 1);
    check("repulse_result", result, 24'h000016);
    check("repulse_ovf_held", ovf, 1'b1);

    // Clear in the 4th MUL cycle aborts without a done pulse.
    a_in = 8'd9; b_in = 8'd9; c_in = 8'd1; acc_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_clear_busy_before", busy, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mid_clear_busy", busy, 1'b0);
    check("mid_clear_result", result, 24'h0);
    check("mid_clear_ovf", ovf, 1'b0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("mid_clear_no_done", ndone, 0);

    // Same scenario with reset; start also held to show reset priority.
    run_op(8'd2, 8'd3, 8'd4, 1'b0, "pre_rst");
    check("pre_rst_result", result, 24'h00000A);
    a_in = 8'd9; b_in = 8'd9; c_in = 8'd1; acc_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1; clear = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0; start = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_result", result, 24'h0);
    check("mid_rst_ovf", ovf, 1'b0);
    check("mid_rst_done", done, 1'b0);

    // Start accepted on the first cycle after reset deasserts.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_op(8'd16, 8'd16, 8'd255, 1'b0, "post_rst");
    check("post_rst_result", result, 24'h0001FF);

    // Clear and start together in IDLE: start ignored.
    clear = 1'b1; start = 1'b1; a_in = 8'd1; b_in = 8'd1; c_in = 8'd1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("clr_start_busy", busy, 1'b0);
    check("clr_start_result", result, 24'h0);
    lat = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy || done) lat++;
      tick();
    end
    check("clr_start_stays_idle", lat, 0);
    check("clr_start_result_hold", result, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
